lcd_spi_write: RTL and testbench

- Serial write engine placed directly downstream of the LCD init/clear sequencer.
- Accepts one 9-bit word at a time: bit 8 is D/C (1 = data, 0 = command), bits 7:0 are the payload.
- Shifts each word out MSB-first on a 4-wire SPI bus (CS, DC, SCK, MOSI) to the ST7789-class panel.
- Returns a one-cycle wr_done per word so the sequencer can advance its word counter.

---
 rtl/lcd_spi_write_if.sv | 34 +++
 rtl/lcd_spi_write.sv | 155 +++++++++++++++
 tb/tb_lcd_spi_write.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_write_if.sv
// Word handshake and 4-wire SPI pins between the
// LCD sequencer, the SPI write engine and the panel.
interface lcd_spi_write_if;
  logic [8:0] data;
  logic       en_write;
  logic       lcd_cs;
  logic       lcd_dc;
  logic       lcd_sck;
  logic       lcd_mosi;
  logic       wr_done;
  logic       busy;

  modport master (
    output data,
    output en_write,
    input  lcd_cs,
    input  lcd_dc,
    input  lcd_sck,
    input  lcd_mosi,
    input  wr_done,
    input  busy
  );

  modport slave (
    input  data,
    input  en_write,
    output lcd_cs,
    output lcd_dc,
    output lcd_sck,
    output lcd_mosi,
    output wr_done,
    output busy
  );
endinterface

// File: rtl/lcd_spi_write.sv
// SPI mode-0 write engine for an ST7789-class panel:
// one 9-bit {dc, byte} word per frame, MSB first.
module lcd_spi_write #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic            sys_clk_50MHz,
  input  logic            sys_rst_n,
  lcd_spi_write_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t     state, state_d;
  logic [7:0] div_cnt, div_d;
  logic [7:0] gap_cnt, gap_d;
  logic [7:0] shreg, shreg_d;
  logic [2:0] bit_cnt, bit_d;
  logic       en_q;
  logic       cs_q, cs_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       dc_q, dc_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       div_end;
  logic       gap_end;

  assign div_end = (div_cnt == 8'(CLK_DIV - 1));
  assign gap_end = (gap_cnt == 8'(GAP_CYC - 1));

  assign bus.lcd_cs   = cs_q;
  assign bus.lcd_sck  = sck_q;
  assign bus.lcd_mosi = mosi_q;
  assign bus.lcd_dc   = dc_q;
  assign bus.wr_done  = done_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      en_q    <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_d;
      div_cnt <= div_d;
      gap_cnt <= gap_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_d;
      en_q    <= bus.en_write;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    gap_d   = gap_cnt;
    shreg_d = shreg;
    bit_d   = bit_cnt;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state)
      IDLE: begin
        div_d = '0;
        cs_d  = 1'b1;
        sck_d = 1'b0;
        // first en_write cycle skipped: data not yet valid
        if (bus.en_write && en_q) begin
          shreg_d = bus.data[7:0];
          dc_d    = bus.data[8];
          mosi_d  = bus.data[7];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        div_d = div_cnt + 8'd1;
        if (div_end) begin
          div_d   = '0;
          sck_d   = 1'b1;
          bit_d   = 3'd7;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_cnt + 8'd1;
        if (div_end) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            if (bit_cnt == 3'd0) begin
              // HOLD covers bit 0's low phase plus CS hold
              bit_d   = 3'd1;
              state_d = HOLD;
            end else begin
              bit_d   = bit_cnt - 3'd1;
              shreg_d = {shreg[6:0], 1'b0};
              mosi_d  = shreg[6];
            end
          end
        end
      end
      HOLD: begin
        div_d = div_cnt + 8'd1;
        if (div_end) begin
          div_d = '0;
          if (bit_cnt == 3'd0) begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            bit_d = bit_cnt - 3'd1;
          end
        end
      end
      GAP: begin
        gap_d = gap_cnt + 8'd1;
        if (gap_end) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Directed bench for lcd_spi_write: decodes SPI frames
// on the pins and compares against hand-computed words.
module tb_lcd_spi_write;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  lcd_spi_write_if bus ();

  lcd_spi_write #(
    .CLK_DIV(2),
    .GAP_CYC(2)
  ) dut (
    .sys_clk_50MHz(clk),
    .sys_rst_n    (rst_n),
    .bus          (bus.slave)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // frame decoder on the pins
  int   nframes = 0;
  int   ndone = 0;
  int   sck_rises = 0;
  int   frm_byte [16];
  int   frm_dc   [16];
  int   frm_len  [16];
  int   frm_e0   [16];
  int   frm_bits [16];
  int   frm_dcbad[16];
  int   done_cyc [16];
  logic in_frame = 1'b0;
  logic prev_sck = 1'b0;
  logic [7:0] cur_byte = '0;
  logic cur_dc = 1'b0;
  logic dc_bad = 1'b0;
  int   cur_len = 0;
  int   cur_bits = 0;
  int   cur_e0 = 0;

  always @(negedge clk) begin
    if (bus.lcd_cs === 1'b0) begin
      if (!in_frame) begin
        in_frame <= 1'b1;
        cur_e0   <= cyc;
        cur_len  <= 1;
        cur_bits <= 0;
        cur_byte <= '0;
        cur_dc   <= bus.lcd_dc;
        dc_bad   <= 1'b0;
      end else begin
        cur_len <= cur_len + 1;
        if (bus.lcd_dc !== cur_dc) dc_bad <= 1'b1;
      end
    end else if (in_frame) begin
      if (nframes < 16) begin
        frm_byte[nframes]  <= int'(cur_byte);
        frm_dc[nframes]    <= int'(cur_dc);
        frm_len[nframes]   <= cur_len;
        frm_e0[nframes]    <= cur_e0;
        frm_bits[nframes]  <= cur_bits;
        frm_dcbad[nframes] <= int'(dc_bad);
      end
      nframes  <= nframes + 1;
      in_frame <= 1'b0;
    end
    if (bus.lcd_sck === 1'b1 && prev_sck === 1'b0) begin
      sck_rises <= sck_rises + 1;
      if (in_frame) begin
        cur_byte <= {cur_byte[6:0], bus.lcd_mosi};
        cur_bits <= cur_bits + 1;
      end
    end
    prev_sck <= bus.lcd_sck;
    if (bus.wr_done === 1'b1) begin
      if (ndone < 16) done_cyc[ndone] <= cyc;
      ndone <= ndone + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.wr_done !== 1'b1 && k < 300);
    chk(tag, int'(bus.wr_done), 1);
  endtask

  task automatic wait_cs_low(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.lcd_cs !== 1'b0 && k < 20);
    chk(tag, int'(bus.lcd_cs), 0);
  endtask

  task automatic chk_frame(input string tag, input int f,
                           input int byt, input int dc);
    chk({tag, "_byte"}, frm_byte[f], byt);
    chk({tag, "_dc"}, frm_dc[f], dc);
    chk({tag, "_bits"}, frm_bits[f], 8);
    chk({tag, "_cslen"}, frm_len[f], 36);
    chk({tag, "_dcstable"}, frm_dcbad[f], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, d0, r0;
    logic [8:0] words [3];
    words[0] = 9'h036;
    words[1] = 9'h160;
    words[2] = 9'h03a;

    bus.data     = 9'h1ff;
    bus.en_write = 1'b1;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_cs", int'(bus.lcd_cs), 1);
    chk("rst_sck", int'(bus.lcd_sck), 0);
    chk("rst_mosi", int'(bus.lcd_mosi), 0);
    chk("rst_dc", int'(bus.lcd_dc), 0);
    chk("rst_done", int'(bus.wr_done), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sck_edges", sck_rises, 0);
    bus.en_write = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single command 0x11
    f0 = nframes;
    d0 = ndone;
    bus.data     = 9'h011;
    bus.en_write = 1'b1;
    wait_done("t1_done");
    bus.en_write = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_nframes", nframes - f0, 1);
    chk("t1_ndone", ndone - d0, 1);
    chk_frame("t1", f0, 8'h11, 0);
    chk("t1_done_lat", done_cyc[d0] - frm_e0[f0], 36);
    chk("t1_idle_busy", int'(bus.busy), 0);

    // start qualification: first en cycle data ignored
    f0 = nframes;
    bus.data     = 9'h000;
    bus.en_write = 1'b1;
    @(negedge clk);
    bus.data = 9'h160;
    wait_done("t2_done");
    bus.en_write = 1'b0;
    repeat (10) @(negedge clk);
    chk("t2_nframes", nframes - f0, 1);
    chk_frame("t2", f0, 8'h60, 1);

    // back-to-back with sequencer model
    f0 = nframes;
    bus.data     = words[0];
    bus.en_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done($sformatf("t3_done%0d", i));
      @(posedge clk);
      @(posedge clk);
      #1;
      if (i < 2) bus.data = words[i+1];
      else bus.en_write = 1'b0;
    end
    repeat (20) @(negedge clk);
    chk("t3_nframes", nframes - f0, 3);
    chk_frame("t3a", f0, 8'h36, 0);
    chk_frame("t3b", f0 + 1, 8'h60, 1);
    chk_frame("t3c", f0 + 2, 8'h3a, 0);
    chk("t3_period1", frm_e0[f0+1] - frm_e0[f0], 39);
    chk("t3_period2", frm_e0[f0+2] - frm_e0[f0+1], 39);
    chk("t3_csgap1",
        int'(frm_e0[f0+1] - frm_e0[f0] - frm_len[f0] >= 3), 1);
    chk("t3_csgap2",
        int'(frm_e0[f0+2] - frm_e0[f0+1] - frm_len[f0+1] >= 3), 1);

    // en_write dropped during bit 3
    f0 = nframes;
    d0 = ndone;
    bus.data     = 9'h1ef;
    bus.en_write = 1'b1;
    wait_cs_low("t4_start");
    repeat (16) @(negedge clk);
    bus.en_write = 1'b0;
    wait_done("t4_done");
    repeat (40) @(negedge clk);
    chk("t4_nframes", nframes - f0, 1);
    chk("t4_ndone", ndone - d0, 1);
    chk_frame("t4", f0, 8'hef, 1);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_cs", int'(bus.lcd_cs), 1);

    // async reset during bit 4
    f0 = nframes;
    bus.data     = 9'h0a5;
    bus.en_write = 1'b1;
    wait_cs_low("t5_start");
    repeat (14) @(negedge clk);
    chk("t5_sck_hi", int'(bus.lcd_sck), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_cs", int'(bus.lcd_cs), 1);
    chk("t5_rst_sck", int'(bus.lcd_sck), 0);
    chk("t5_rst_busy", int'(bus.busy), 0);
    bus.data = 9'h02a;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r0 = cyc;
    wait_done("t5_done");
    bus.en_write = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_nframes", nframes - f0, 2);
    chk("t5_abort_bits", frm_bits[f0], 4);
    chk_frame("t5", f0 + 1, 8'h2a, 0);
    chk("t5_e0", frm_e0[f0+1] - r0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
